fnd_time_display: RTL and testbench
===================================

FND_TIME_DISPLAY -- requirements
Module: fnd_time_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, i_clk cycles per digit slot (1 kHz digit rate at 100 MHz).
REQ-002 SHALL have parameter BLINK_FRAMES, default 125, scan frames per decimal-point toggle (0.5 s at default rate).
REQ-003 SHALL have port i_clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port i_reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports i_min, i_sec, i_msec  input  7 each  binary time fields from the time counter (msec already in 0..99 units of 10 ms).
REQ-006 SHALL have port i_mode  input  1  0 = MM.SS view, 1 = SS.cc view.
REQ-007 SHALL have port o_fnd_com  output  4  active-low digit enables; bit 3 = leftmost digit.
REQ-008 SHALL have port o_fnd_font  output  8  active-low segments {dp,g,f,e,d,c,b,a}.

Function
REQ-009 SHALL run a prescaler counting 0..SCAN_DIV-1; the terminal count is a one-cycle slot tick.
REQ-010 SHALL advance a 2-bit digit index 0->1->2->3->0 on each slot tick; index 0 = rightmost digit.
REQ-011 SHALL drive exactly one o_fnd_com bit low at all times out of reset, matching the digit index.
REQ-012 SHALL capture i_min, i_sec, i_msec and i_mode into snapshot registers on the slot tick that wraps index 3->0; digits of one frame always come from one snapshot (no tearing).
REQ-013 SHALL select left pair/right pair as min/sec when snapshot mode = 0, sec/msec when 1.
REQ-014 SHALL clamp any field value > 99 to 99 before conversion.
REQ-015 SHALL convert each pair value to tens = value/10, units = value%10, both 0..9.
REQ-016 SHALL update o_fnd_com and o_fnd_font on the same clock edge as the index changes (registered outputs, no cycle skew between them).
REQ-017 SHALL encode digits 0..9 with standard 7-segment patterns; unused codes render blank (8'hFF).
REQ-018 SHALL light dp (bit 7 = 0) only on digit index 2, and only while the blink flag is 1.
REQ-019 SHALL toggle the blink flag every BLINK_FRAMES completed frames (frame counter increments on index 3->0 wrap).
REQ-020 SHALL hold dp steadily lit when snapshot mode = 1 (stopwatch view), blinking only in mode 0.
REQ-021 SHALL treat a mode change mid-frame as taking effect at the next frame start only.

Reset
REQ-022 SHALL, when i_reset = 0 at a rising edge, clear prescaler, digit index, frame counter and snapshots to 0 and set the blink flag to 1.
REQ-023 SHALL drive o_fnd_com = 4'b1110 and o_fnd_font = 8'hFF during and on the first cycle after reset.
REQ-024 SHALL restart scanning from digit 0 with a full SCAN_DIV slot after reset deassertion, regardless of when reset asserted mid-slot.

Configuration
REQ-025 SHALL support macro FND_LEAD_ZERO_BLANK_EN: defined -> leftmost digit (index 3) renders blank when its tens value is 0; undefined -> all four digits always show numerals, including leading zero.

Structure
REQ-026 SHALL place segment pattern constants (digits 0..9, blank), digit-index constants and the mode encoding in shared package fnd_pkg.
REQ-027 SHALL implement BCD-to-segment encoding in combinational sub-module fnd_seg_decoder (4-bit digit in, 7-bit active-low segments out), instantiated once.

Verification (SCAN_DIV = 4, BLINK_FRAMES = 2 for simulation)
REQ-028 SHALL test reset: i_reset = 0 for 3 cycles -> o_fnd_com = 1110, o_fnd_font = FF; after release, o_fnd_com changes to 1101 exactly 4 cycles later.
REQ-029 SHALL test MM.SS view: i_mode = 0, min = 12, sec = 34 -> over one frame, digits 3..0 show 1,2,3,4 with dp on digit 2 only while blinking.
REQ-030 SHALL test SS.cc view: i_mode = 1, sec = 59, msec = 7 -> digits 5,9,0,7 with steady dp on digit 2.
REQ-031 SHALL test clamping and boundary: sec = 60 shows 6,0; min = 120 shows 9,9.
REQ-032 SHALL test no tearing: change sec from 09 to 10 while index = 1 -> current frame still shows 0,9; next frame shows 1,0.
REQ-033 SHALL test blink period: dp on digit 2 toggles every 2 frames (32 cycles) in mode 0; with FND_LEAD_ZERO_BLANK_EN, min = 5 renders digit 3 as FF.

Source files
------------

// File: rtl/fnd_pkg.sv
// fnd_pkg: shared constants for the 4-digit FND time display.
// Holds the segment patterns, the digit-index map and the view-mode encoding.
package fnd_pkg;

   // View mode: minutes.seconds, or seconds.centiseconds (stopwatch view)
   typedef enum logic {
      MODE_MMSS = 1'b0,
      MODE_SSCC = 1'b1
   } disp_mode_e;

   // Digit index map; index 0 is the rightmost digit
   localparam logic [1:0] IDX_UNITS_R = 2'd0;
   localparam logic [1:0] IDX_TENS_R  = 2'd1;
   localparam logic [1:0] IDX_UNITS_L = 2'd2;
   localparam logic [1:0] IDX_TENS_L  = 2'd3;
   localparam logic [1:0] IDX_DP      = IDX_UNITS_L;

   // Active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Full font (dp included) for a dark digit, and the common pattern out of reset
   localparam logic [7:0] FONT_BLANK = 8'hFF;
   localparam logic [3:0] COM_RESET  = 4'b1110;

   // Time fields are 7 bits wide but the display holds two decimal digits
   function automatic logic [6:0] clamp99(input logic [6:0] v);
      return (v > 7'd99) ? 7'd99 : v;
   endfunction

endpackage

// File: rtl/fnd_time_display_if.sv
// fnd_time_display_if: bundles the time-counter side and the display pins of
// fnd_time_display. The time source is the master, the display is the slave.
interface fnd_time_display_if;

   logic [6:0] time_min;
   logic [6:0] time_sec;
   logic [6:0] time_msec;
   logic       time_mode;
   logic [3:0] fnd_com;
   logic [7:0] fnd_font;

   modport master (
      output time_min, time_sec, time_msec, time_mode,
      input  fnd_com, fnd_font
   );

   modport slave (
      input  time_min, time_sec, time_msec, time_mode,
      output fnd_com, fnd_font
   );

endinterface

// File: rtl/fnd_seg_decoder.sv
// fnd_seg_decoder: combinational BCD digit to active-low 7-segment pattern.
// Codes 10..15 render blank.
module fnd_seg_decoder
   import fnd_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   // Pattern lookup, blank for anything that is not a decimal digit
   always_comb begin
      seg_o = SEG_BLANK;
      case (digit_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/fnd_time_display.sv
// fnd_time_display: multiplexed 4-digit FND driver for a MM.SS / SS.cc clock.
// Each frame scans digits 0..3; the time fields and view mode are snapshotted
// at frame start so a frame never mixes two input values.
// Optional feature macro: FND_LEAD_ZERO_BLANK_EN blanks the leftmost digit
// when its value is a leading zero.
module fnd_time_display
   import fnd_pkg::*;
#(
   parameter int SCAN_DIV     = 100000,
   parameter int BLINK_FRAMES = 125
)(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [6:0] i_min,
   input  logic [6:0] i_sec,
   input  logic [6:0] i_msec,
   input  logic       i_mode,
   output logic [3:0] o_fnd_com,
   output logic [7:0] o_fnd_font
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    idx_q, idx_d;
   logic [FW-1:0] frame_q, frame_d;
   logic          blink_q, blink_d;
   logic [6:0]    min_q, min_d;
   logic [6:0]    sec_q, sec_d;
   logic [6:0]    msec_q, msec_d;
   disp_mode_e    mode_q, mode_d;
   logic [3:0]    com_q, com_d;
   logic [7:0]    font_q, font_d;

   logic          slot_tick;
   logic          frame_wrap;
   logic [6:0]    left_val, right_val, pair_val;
   logic [3:0]    tens_val, units_val, digit_val;
   logic [6:0]    seg_n;
   logic          dp_n;
   logic          lead_blank;

   // Slot prescaler, digit index, and the frame counter that paces the dp blink
   always_comb begin
      slot_tick  = (presc_q == PRESC_LAST);
      presc_d    = slot_tick ? '0 : presc_q + 1'b1;
      idx_d      = slot_tick ? idx_q + 2'd1 : idx_q;
      frame_wrap = slot_tick && (idx_q == IDX_TENS_L);
      frame_d    = frame_q;
      blink_d    = blink_q;
      if (frame_wrap) begin
         if (frame_q == FRAME_LAST) begin
            frame_d = '0;
            blink_d = ~blink_q;
         end else begin
            frame_d = frame_q + 1'b1;
         end
      end
   end

   // Input snapshot taken only at frame start; the _d side feeds the first digit of the new frame
   always_comb begin
      min_d  = min_q;
      sec_d  = sec_q;
      msec_d = msec_q;
      mode_d = mode_q;
      if (frame_wrap) begin
         min_d  = i_min;
         sec_d  = i_sec;
         msec_d = i_msec;
         mode_d = disp_mode_e'(i_mode);
      end
   end

   // Pick the pair and the decimal digit that belong to the upcoming index
   always_comb begin
      left_val  = clamp99((mode_d == MODE_SSCC) ? sec_d : min_d);
      right_val = clamp99((mode_d == MODE_SSCC) ? msec_d : sec_d);
      pair_val  = idx_d[1] ? left_val : right_val;
      tens_val  = 4'(pair_val / 7'd10);
      units_val = 4'(pair_val % 7'd10);
      digit_val = idx_d[0] ? tens_val : units_val;
   end

   fnd_seg_decoder u_seg_decoder (
      .digit_i (digit_val),
      .seg_o   (seg_n)
   );

`ifdef FND_LEAD_ZERO_BLANK_EN
   assign lead_blank = (idx_d == IDX_TENS_L) && (tens_val == 4'd0);
`else
   assign lead_blank = 1'b0;
`endif

   // Outputs only move on a slot tick so common and font switch together with the index
   always_comb begin
      com_d  = com_q;
      font_d = font_q;
      dp_n   = ~((idx_d == IDX_DP) && ((mode_d == MODE_SSCC) || blink_d));
      if (slot_tick) begin
         com_d  = ~(4'b0001 << idx_d);
         font_d = lead_blank ? FONT_BLANK : {dp_n, seg_n};
      end
   end

   // State registers; reset restarts a full slot at digit 0 with a dark digit
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         presc_q <= '0;
         idx_q   <= IDX_UNITS_R;
         frame_q <= '0;
         blink_q <= 1'b1;
         min_q   <= '0;
         sec_q   <= '0;
         msec_q  <= '0;
         mode_q  <= MODE_MMSS;
         com_q   <= COM_RESET;
         font_q  <= FONT_BLANK;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         frame_q <= frame_d;
         blink_q <= blink_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         msec_q  <= msec_d;
         mode_q  <= mode_d;
         com_q   <= com_d;
         font_q  <= font_d;
      end
   end

   assign o_fnd_com  = com_q;
   assign o_fnd_font = font_q;

endmodule

// File: tb/tb_fnd_time_display.sv
// tb_fnd_time_display: scoreboard bench for fnd_time_display (SCAN_DIV=4, BLINK_FRAMES=2).
// The stimulus process sets each frame's inputs mid-way through the previous
// frame and queues that frame's expected digits; the monitor pops one entry per
// digit change. Also honours FND_LEAD_ZERO_BLANK_EN.
module tb_fnd_time_display;

   localparam int SD = 4;
   localparam int BF = 2;
   localparam int NF = 26;

   typedef struct {
      logic [3:0] com;
      logic [7:0] font;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst_at_edge = 1'b0;

   fnd_time_display_if dif();

   fnd_time_display #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
      .i_clk      (clk),
      .i_reset    (rst_n),
      .i_min      (dif.time_min),
      .i_sec      (dif.time_sec),
      .i_msec     (dif.time_msec),
      .i_mode     (dif.time_mode),
      .o_fnd_com  (dif.fnd_com),
      .o_fnd_font (dif.fnd_font)
   );

   always #5 clk = ~clk;

   // Standard active-low patterns {g,f,e,d,c,b,a} for 0..9 and the per-digit commons
   logic [6:0] seg_ref [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   logic [3:0] com_ref [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Directed frames first: 12:34, 59.07 stopwatch, clamps, 09 -> 10, saturation
   int d_min  [0:6] = '{12, 0,  120, 5, 5,  12, 127};
   int d_sec  [0:6] = '{34, 59, 60,  9, 10, 34, 127};
   int d_msec [0:6] = '{0,  7,  0,   0, 0,  0,  127};
   int d_mode [0:6] = '{0,  1,  0,   0, 0,  0,  1};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // What one digit of a frame should look like, from the display rules alone
   function automatic logic [7:0] ref_font(input int idx, input int mn, input int sc,
                                           input int ms, input int md, input bit blink);
      int  l, r, v, d;
      bit  dp_on;
      l = (md != 0) ? sc : mn;
      r = (md != 0) ? ms : sc;
      if (l > 99) l = 99;
      if (r > 99) r = 99;
      v = (idx >= 2) ? l : r;
      d = (idx == 1 || idx == 3) ? v / 10 : v % 10;
`ifdef FND_LEAD_ZERO_BLANK_EN
      if (idx == 3 && d == 0) return 8'hFF;
`endif
      dp_on = (idx == 2) && ((md != 0) || blink);
      return {~dp_on, seg_ref[d]};
   endfunction

   task automatic push_frame(input int f, input int mn, input int sc, input int ms, input int md);
      bit   blink;
      exp_t e;
      blink = (((f / BF) % 2) == 0);
      for (int idx = (f == 0) ? 1 : 0; idx < 4; idx++) begin
         e.com  = com_ref[idx];
         e.font = ref_font(idx, mn, sc, ms, md, blink);
         exp_q.push_back(e);
      end
   endtask

   // Stimulus: reset, then one input set per frame, each applied while the previous frame shows index 1
   initial begin
      int mn, sc, ms, md;
      dif.time_min  = 7'd0;
      dif.time_sec  = 7'd0;
      dif.time_msec = 7'd0;
      dif.time_mode = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      push_frame(0, 0, 0, 0, 0);
      for (int f = 1; f <= NF; f++) begin
         repeat ((f == 1) ? 5 : 16) @(negedge clk);
         if (f <= 7) begin
            mn = d_min[f-1];
            sc = d_sec[f-1];
            ms = d_msec[f-1];
            md = d_mode[f-1];
         end else begin
            mn = int'($urandom_range(0, 127));
            sc = int'($urandom_range(0, 127));
            ms = int'($urandom_range(0, 127));
            md = int'($urandom_range(0, 1));
         end
         dif.time_min  = 7'(mn);
         dif.time_sec  = 7'(sc);
         dif.time_msec = 7'(ms);
         dif.time_mode = md[0];
         push_frame(f, mn, sc, ms, md);
      end
      for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
      check("drain_remaining", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   always @(posedge clk) rst_at_edge <= rst_n;

   // Monitor: every digit change is one transaction, checked against the queue head
   always @(negedge clk) begin
      static int  slot_cyc   = 0;
      static bit  first_slot = 1'b1;
      static logic [3:0] prev_com = 4'b1110;
      exp_t e;
      if (!rst_at_edge) begin
         check("reset_com", 32'(dif.fnd_com), 32'h0E);
         check("reset_font", 32'(dif.fnd_font), 32'hFF);
         slot_cyc   = 0;
         first_slot = 1'b1;
         prev_com   = dif.fnd_com;
      end else begin
         slot_cyc++;
         if (dif.fnd_com !== prev_com) begin
            check("slot_length", 32'(slot_cyc), 32'(SD));
            if (exp_q.size() == 0) begin
               check("unexpected_slot", 32'(dif.fnd_com), 32'hF);
            end else begin
               e = exp_q.pop_front();
               $display("[TB] slot com=%b font=%h expect com=%b font=%h",
                        dif.fnd_com, dif.fnd_font, e.com, e.font);
               check("slot_com", 32'(dif.fnd_com), 32'(e.com));
               check("slot_font", 32'(dif.fnd_font), 32'(e.font));
            end
            prev_com   = dif.fnd_com;
            slot_cyc   = 0;
            first_slot = 1'b0;
         end else if (first_slot) begin
            check("post_reset_com", 32'(dif.fnd_com), 32'h0E);
            check("post_reset_font", 32'(dif.fnd_font), 32'hFF);
         end else if (slot_cyc == SD + 1) begin
            check("slot_stalled", 32'(slot_cyc), 32'(SD));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, queue=%0d", exp_q.size());
      $fatal(1, "watchdog expired");
   end

endmodule
